// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
// Shares one single-port data memory between two requesters. Port 0 is the
// core load/store path and port 1 is a loader or debug master. Arbitration is
// round-robin with a bounded burst, so neither port can starve the other.
// Grants are combinational. Load data is captured from the memory's
// asynchronous read port and returned one cycle after the grant.
module data_mem_arbiter #(
   parameter int MAX_BURST = 4,
   parameter int AW        = 32,
   parameter int DW        = 32
) (
   input  logic          clk,
   input  logic          reset,
   // port 0: core load/store path
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          gnt0,
   output logic          rvalid0,
   output logic [DW-1:0] rdata0,
   // port 1: loader / debug master
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          gnt1,
   output logic          rvalid1,
   output logic [DW-1:0] rdata1,
   // memory side
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam int BW = $clog2(MAX_BURST + 1);
   localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
   localparam logic [BW-1:0] BURST_ONE = BW'(1);

   // Owner is the port that most recently won; it keeps winning contention
   // until it has used up its burst allowance.
   typedef enum logic {
      OWN_P0 = 1'b0,
      OWN_P1 = 1'b1
   } owner_e;

   owner_e        owner;
   owner_e        owner_nxt;
   owner_e        gnt_port;
   logic [BW-1:0] burst_cnt;
   logic [BW-1:0] burst_cnt_nxt;
   logic          burst_full;
   logic          any_gnt;
   logic          load0;
   logic          load1;

   assign burst_full = (burst_cnt >= BURST_MAX);
   assign any_gnt    = gnt0 | gnt1;
   assign load0      = gnt0 & ~we0;
   assign load1      = gnt1 & ~we1;

   // Grant decision: lone requester wins; under contention the owner wins
   // until its burst is exhausted. Nothing is granted while reset is high.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch so
      // no path leaves it unassigned, which would otherwise infer a latch.
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!reset) begin
         case ({req1, req0})
            2'b01: gnt0 = 1'b1;
            2'b10: gnt1 = 1'b1;
            2'b11: begin
               if ((owner == OWN_P1) ^ burst_full) gnt1 = 1'b1;
               else                                gnt0 = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Next arbitration state: extend the owner's burst (saturating), hand
   // ownership to a newly granted port, or clear the burst on an idle cycle.
   always_comb begin
      owner_nxt     = owner;
      burst_cnt_nxt = '0;
      gnt_port      = gnt1 ? OWN_P1 : OWN_P0;
      if (any_gnt) begin
         if (gnt_port == owner) begin
            burst_cnt_nxt = burst_full ? burst_cnt : burst_cnt + BURST_ONE;
         end else begin
            owner_nxt     = gnt_port;
            burst_cnt_nxt = BURST_ONE;
         end
      end
   end

   // Arbitration state register; reset hands ownership back to port 0.
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement or block order.
      if (reset) begin
         owner     <= OWN_P0;
         burst_cnt <= '0;
      end else begin
         owner     <= owner_nxt;
         burst_cnt <= burst_cnt_nxt;
      end
   end

   // Memory mux: the granted port drives the memory; port 0 is parked on the
   // bus when idle, and only a granted store can raise the write enable.
   always_comb begin
      mem_we    = (gnt0 & we0) | (gnt1 & we1);
      mem_addr  = addr0;
      mem_wdata = wdata0;
      if (gnt1) begin
         mem_addr  = addr1;
         mem_wdata = wdata1;
      end
   end

   // Read return: capture the asynchronous read of a granted load and strobe
   // the matching rvalid one cycle later; data holds between loads.
   always_ff @(posedge clk) begin
      if (reset) begin
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         rdata0  <= '0;
         rdata1  <= '0;
      end else begin
         rvalid0 <= load0;
         rvalid1 <= load1;
         if (load0) rdata0 <= mem_rdata;
         if (load1) rdata1 <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter
// Drives two arbiters (MAX_BURST=4 and MAX_BURST=1) with identical stimulus,
// each backed by its own behavioural memory, and compares every output every
// cycle against a reference model built from the arbitration rules.
module tb_data_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NDUT = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic          init_mem;
   logic          req0, we0, req1, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;

   logic [NDUT-1:0] gnt0_v, gnt1_v, rv0_v, rv1_v, mwe_v;
   logic [DW-1:0]   rd0_v [NDUT];
   logic [DW-1:0]   rd1_v [NDUT];
   logic [DW-1:0]   mwd_v [NDUT];
   logic [DW-1:0]   mrd_v [NDUT];
   logic [AW-1:0]   ma_v  [NDUT];

   data_mem_arbiter #(.MAX_BURST(4), .AW(AW), .DW(DW)) dut_b4 (
      .clk(clk), .reset(reset),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .gnt0(gnt0_v[0]), .rvalid0(rv0_v[0]), .rdata0(rd0_v[0]),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt1(gnt1_v[0]), .rvalid1(rv1_v[0]), .rdata1(rd1_v[0]),
      .mem_we(mwe_v[0]), .mem_addr(ma_v[0]), .mem_wdata(mwd_v[0]),
      .mem_rdata(mrd_v[0])
   );

   data_mem_arbiter #(.MAX_BURST(1), .AW(AW), .DW(DW)) dut_b1 (
      .clk(clk), .reset(reset),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .gnt0(gnt0_v[1]), .rvalid0(rv0_v[1]), .rdata0(rd0_v[1]),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt1(gnt1_v[1]), .rvalid1(rv1_v[1]), .rdata1(rd1_v[1]),
      .mem_we(mwe_v[1]), .mem_addr(ma_v[1]), .mem_wdata(mwd_v[1]),
      .mem_rdata(mrd_v[1])
   );

   function automatic logic [DW-1:0] init_word(input int i);
      if (i == 4) return 32'hDEADBEEF;
      return 32'h1000_0000 + DW'(i) * 32'h0101_0101;
   endfunction

   // 64-word memory per DUT, indexed by word address bits [7:2]
   for (genvar k = 0; k < NDUT; k++) begin : g_env
      logic [DW-1:0] mem [64];
      always @(posedge clk) begin
         if (init_mem) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
         end else if (mwe_v[k]) begin
            mem[ma_v[k][7:2]] <= mwd_v[k];
         end
      end
      assign mrd_v[k] = mem[ma_v[k][7:2]];
   end

   // Reference model: which port was granted last, how many consecutive
   // grants it has had (unbounded), and the responses due next cycle.
   typedef struct {
      int            holder;
      int            run;
      bit            rv0;
      bit            rv1;
      logic [DW-1:0] rd0;
      logic [DW-1:0] rd1;
   } mdl_t;

   mdl_t          m [NDUT];
   logic [DW-1:0] ref_mem [NDUT][64];
   int            max_b [NDUT] = '{4, 1};

   int total = 0;
   int bad   = 0;
   bit last_g0 [NDUT];
   bit last_g1 [NDUT];
   bit exp_g0_last;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic expect_grant(input int k, output bit g0, output bit g1);
      int who;
      g0 = 1'b0;
      g1 = 1'b0;
      if (!reset) begin
         if (req0 && !req1)      g0 = 1'b1;
         else if (req1 && !req0) g1 = 1'b1;
         else if (req0 && req1) begin
            who = (m[k].run >= max_b[k]) ? 1 - m[k].holder : m[k].holder;
            if (who == 0) g0 = 1'b1;
            else          g1 = 1'b1;
         end
      end
   endtask

   // One clock: check all outputs mid-cycle, advance the model, then step
   // to just after the next rising edge.
   task automatic cycle();
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
         bit            g0, g1;
         bit            exp_we;
         logic [AW-1:0] ea;
         logic [DW-1:0] ew;
         int            p;
         expect_grant(k, g0, g1);
         exp_we = (g0 && we0) || (g1 && we1);
         ea = g1 ? addr1 : addr0;
         ew = g1 ? wdata1 : wdata0;
         check($sformatf("d%0d gnt0", k), 32'(gnt0_v[k]), 32'(g0));
         check($sformatf("d%0d gnt1", k), 32'(gnt1_v[k]), 32'(g1));
         check($sformatf("d%0d excl", k), 32'(gnt0_v[k] & gnt1_v[k]), 32'd0);
         check($sformatf("d%0d mem_we", k), 32'(mwe_v[k]), 32'(exp_we));
         check($sformatf("d%0d mem_addr", k), ma_v[k], ea);
         check($sformatf("d%0d mem_wdata", k), mwd_v[k], ew);
         check($sformatf("d%0d rvalid0", k), 32'(rv0_v[k]), 32'(m[k].rv0));
         check($sformatf("d%0d rvalid1", k), 32'(rv1_v[k]), 32'(m[k].rv1));
         check($sformatf("d%0d rdata0", k), rd0_v[k], m[k].rd0);
         check($sformatf("d%0d rdata1", k), rd1_v[k], m[k].rd1);
         last_g0[k] = gnt0_v[k];
         last_g1[k] = gnt1_v[k];
         if (k == 0) exp_g0_last = g0;
         if (reset) begin
            m[k] = '{0, 0, 1'b0, 1'b0, '0, '0};
         end else begin
            if (g0 || g1) begin
               p = g1 ? 1 : 0;
               if (p == m[k].holder) m[k].run++;
               else begin
                  m[k].holder = p;
                  m[k].run    = 1;
               end
            end else begin
               m[k].run = 0;
            end
            m[k].rv0 = g0 && !we0;
            m[k].rv1 = g1 && !we1;
            if (m[k].rv0) m[k].rd0 = ref_mem[k][addr0[7:2]];
            if (m[k].rv1) m[k].rd1 = ref_mem[k][addr1[7:2]];
            if (exp_we) ref_mem[k][ea[7:2]] = ew;
         end
      end
      @(posedge clk);
      #1;
   endtask

   int seq_b4 [8] = '{0, 0, 0, 0, 1, 1, 1, 1};

   initial begin
      reset = 1'b1; init_mem = 1'b1;
      req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
      req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
      exp_g0_last = 1'b0;
      for (int k = 0; k < NDUT; k++) begin
         m[k] = '{0, 0, 1'b0, 1'b0, '0, '0};
         for (int i = 0; i < 64; i++) ref_mem[k][i] = init_word(i);
      end
      @(posedge clk);
      #1;
      init_mem = 1'b0;

      // reset held with a port 1 store pending: no grant, no write
      req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'h1234_5678;
      cycle();
      cycle();
      reset = 1'b0; req1 = 1'b0; we1 = 1'b0;

      // single port 0 load of 0x10
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
      cycle();
      req0 = 1'b0;
      check("p0 load rvalid0", 32'(rv0_v[0]), 32'd1);
      check("p0 load rdata0", rd0_v[0], 32'hDEADBEEF);
      check("p0 load rvalid1", 32'(rv1_v[0]), 32'd0);
      cycle();

      // both ports load continuously: burst of 4 vs strict alternation
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
      req1 = 1'b1; we1 = 1'b0; addr1 = 32'h14;
      for (int i = 0; i < 12; i++) begin
         cycle();
         check($sformatf("seq b4 %0d", i), 32'(last_g1[0]), 32'(seq_b4[i % 8]));
         check($sformatf("seq b1 %0d", i), 32'(last_g1[1]), 32'(i % 2));
      end
      req0 = 1'b0; req1 = 1'b0;
      cycle();

      // port 1 stores to 0x20, then port 0 loads it back
      req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'h5A5A5A5A;
      cycle();
      req1 = 1'b0; we1 = 1'b0;
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h20;
      cycle();
      req0 = 1'b0;
      check("st/ld rvalid0", 32'(rv0_v[0]), 32'd1);
      check("st/ld rdata0", rd0_v[0], 32'h5A5A5A5A);
      cycle();

      // port 0 twice, one idle cycle, then contention: owner keeps 4 grants
      req0 = 1'b1; addr0 = 32'h08;
      cycle();
      cycle();
      req0 = 1'b0;
      cycle();
      req0 = 1'b1; req1 = 1'b1; we1 = 1'b0; addr1 = 32'h0C;
      for (int i = 0; i < 8; i++) begin
         cycle();
         check($sformatf("idle seq %0d", i), 32'(last_g1[0]), 32'(seq_b4[i]));
      end
      req0 = 1'b0; req1 = 1'b0;
      cycle();

      // reset right after a granted load kills the response
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
      cycle();
      req0 = 1'b0; reset = 1'b1;
      cycle();
      check("rst rvalid0 b4", 32'(rv0_v[0]), 32'd0);
      check("rst rvalid0 b1", 32'(rv0_v[1]), 32'd0);
      reset = 1'b0;
      cycle();

      // randomized traffic with requests held until granted
      for (int n = 0; n < 3000; n++) begin
         reset = ($urandom_range(0, 99) < 2);
         if (!req0 || exp_g0_last || $urandom_range(0, 15) == 0) begin
            req0   = 1'($urandom_range(0, 1));
            we0    = 1'($urandom_range(0, 1));
            addr0  = $urandom;
            wdata0 = $urandom;
         end
         if (!req1 || last_g1[0] || $urandom_range(0, 15) == 0) begin
            req1   = 1'($urandom_range(0, 1));
            we1    = 1'($urandom_range(0, 1));
            addr1  = $urandom;
            wdata1 = $urandom;
         end
         cycle();
      end
      reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
      cycle();

      // final memory contents must match every expected write
      for (int i = 0; i < 64; i++) begin
         check($sformatf("mem b4 %0d", i), g_env[0].mem[i], ref_mem[0][i]);
         check($sformatf("mem b1 %0d", i), g_env[1].mem[i], ref_mem[1][i]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
